// File: rtl/gf180mcu_osu_sc_12t_inv_pipe.sv
// rtl/gf180mcu_osu_sc_12t_inv_pipe.sv - elastic DEPTH-stage pipe with per-beat optional inversion
//
// Purpose: carries a WIDTH-bit bus through DEPTH registered stages with a
// valid/ready handshake. Each beat is stored inverted or straight at accept
// time, selected by INV, and keeps that polarity all the way to Y.
//
// Ports:
//   CLK      in   rising-edge clock
//   RN       in   asynchronous active-low reset
//   A        in   input data beat (WIDTH)
//   A_VALID  in   upstream beat present
//   A_READY  out  pipe accepts a beat this cycle
//   INV      in   1 = store ~A, 0 = store A (sampled on accept)
//   FLUSH    in   synchronous discard of all held beats
//   Y        out  output data, stage DEPTH-1 (WIDTH)
//   Y_VALID  out  output beat present
//   Y_READY  in   downstream accepts
//   COUNT    out  number of occupied stages, 0..DEPTH (CW)
module gf180mcu_osu_sc_12t_inv_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] A,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic             INV,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] Y,
  output logic             Y_VALID,
  input  logic             Y_READY,
  output logic [CW-1:0]    COUNT
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  // r[i]: stage i may take a new beat this cycle; r[DEPTH] is the downstream ready.
  logic [DEPTH:0]   r;
  logic             acc;
  logic             a_fire;
  logic             y_fire;

  // A stage is ready when it, or any stage downstream of it, is empty, or
  // the output is being taken. The OR is accumulated from the output side so
  // the chain never reads its own result.
  always_comb begin
    acc      = Y_READY;
    r        = '0;
    r[DEPTH] = Y_READY;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc  = acc | ~v[i];
      r[i] = acc;
    end
  end

  // RN in the ready term forces A_READY low while reset is held.
  assign A_READY = r[0] & ~FLUSH & RN;
  assign a_fire  = A_VALID & A_READY;
  assign y_fire  = v[DEPTH-1] & Y_READY;
  assign Y       = d[DEPTH-1];
  assign Y_VALID = v[DEPTH-1];

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      v     <= '0;
      COUNT <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
      end
    end else begin
      // Data only ever moves forward with a beat; nothing rewrites a held beat.
      if (a_fire) begin
        d[0] <= INV ? ~A : A;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (v[i-1] && r[i]) begin
          d[i] <= d[i-1];
        end
      end

      if (FLUSH) begin
        // Data registers are left as they are; only occupancy is discarded.
        v     <= '0;
        COUNT <= '0;
      end else begin
        // A stage is full next cycle if it is refilled, or if it holds a beat
        // that cannot move on.
        v[0] <= a_fire | (v[0] & ~r[1]);
        for (int i = 1; i < DEPTH; i++) begin
          v[i] <= (v[i-1] & r[i]) | (v[i] & ~r[i+1]);
        end
        if (a_fire && !y_fire) begin
          COUNT <= COUNT + CW'(1);
        end else if (!a_fire && y_fire) begin
          COUNT <= COUNT - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_inv_pipe.sv
// tb/tb_gf180mcu_osu_sc_12t_inv_pipe.sv - self-checking bench for the inverting elastic pipe
//
// Three configurations share one stimulus: 8x4, 1x1 and 64x16. Each has a
// queue model: a beat is visible DEPTH-1 edges after its accept, but never
// before the edge on which the beat ahead of it was taken.
module tb_gf180mcu_osu_sc_12t_inv_pipe;

  logic        clk = 1'b0;
  logic        rn;
  logic [63:0] a;
  logic        a_valid;
  logic        inv;
  logic        flush;
  logic        y_ready;

  logic        a_ready0, a_ready1, a_ready2;
  logic        y_valid0, y_valid1, y_valid2;
  logic [7:0]  y0;
  logic [0:0]  y1;
  logic [63:0] y2;
  logic [2:0]  count0;
  logic [0:0]  count1;
  logic [4:0]  count2;

  int nvec = 0;
  int nerr = 0;
  int ecnt = 0;

  logic [63:0] mdat [3][16];
  int          mav  [3][16];
  int          mhead[3];
  int          msize[3];

  always #5 clk = ~clk;

  gf180mcu_osu_sc_12t_inv_pipe #(.WIDTH(8), .DEPTH(4)) dut0 (
    .CLK(clk), .RN(rn), .A(a[7:0]), .A_VALID(a_valid), .A_READY(a_ready0),
    .INV(inv), .FLUSH(flush), .Y(y0), .Y_VALID(y_valid0), .Y_READY(y_ready),
    .COUNT(count0)
  );

  gf180mcu_osu_sc_12t_inv_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
    .CLK(clk), .RN(rn), .A(a[0:0]), .A_VALID(a_valid), .A_READY(a_ready1),
    .INV(inv), .FLUSH(flush), .Y(y1), .Y_VALID(y_valid1), .Y_READY(y_ready),
    .COUNT(count1)
  );

  gf180mcu_osu_sc_12t_inv_pipe #(.WIDTH(64), .DEPTH(16)) dut2 (
    .CLK(clk), .RN(rn), .A(a), .A_VALID(a_valid), .A_READY(a_ready2),
    .INV(inv), .FLUSH(flush), .Y(y2), .Y_VALID(y_valid2), .Y_READY(y_ready),
    .COUNT(count2)
  );

  function automatic int dep_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(input int k);
    case (k)
      0:       return 64'hFF;
      1:       return 64'h1;
      default: return {64{1'b1}};
    endcase
  endfunction

  function automatic logic [63:0] obs_y(input int k);
    case (k)
      0:       return 64'(y0);
      1:       return 64'(y1);
      default: return y2;
    endcase
  endfunction

  function automatic logic [63:0] obs_v(input int k);
    case (k)
      0:       return 64'(y_valid0);
      1:       return 64'(y_valid1);
      default: return 64'(y_valid2);
    endcase
  endfunction

  function automatic logic [63:0] obs_r(input int k);
    case (k)
      0:       return 64'(a_ready0);
      1:       return 64'(a_ready1);
      default: return 64'(a_ready2);
    endcase
  endfunction

  function automatic logic [63:0] obs_c(input int k);
    case (k)
      0:       return 64'(count0);
      1:       return 64'(count1);
      default: return 64'(count2);
    endcase
  endfunction

  function automatic bit exp_valid(input int k);
    return (msize[k] > 0) && (mav[k][mhead[k]] <= ecnt);
  endfunction

  function automatic bit exp_ready(input int k);
    return (rn === 1'b1) && !flush && ((msize[k] < dep_of(k)) || y_ready);
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      msize[k] = 0;
      mhead[k] = 0;
    end
  endtask

  task automatic chk_reset_outputs();
    for (int k = 0; k < 3; k++) begin
      chk("rst_y_valid", k, obs_v(k), 64'd0);
      chk("rst_y", k, obs_y(k), 64'd0);
      chk("rst_count", k, obs_c(k), 64'd0);
      chk("rst_a_ready", k, obs_r(k), 64'd0);
    end
  endtask

  // One clock: check A_READY before the edge, advance the model at the edge,
  // then check the registered outputs #1 later.
  task automatic cycle();
    bit af [3];
    bit yf [3];
    int idx;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("a_ready", k, obs_r(k), 64'(exp_ready(k)));
      af[k] = a_valid && exp_ready(k);
      yf[k] = exp_valid(k) && y_ready;
    end
    @(posedge clk);
    ecnt++;
    for (int k = 0; k < 3; k++) begin
      if (yf[k]) begin
        mhead[k] = (mhead[k] + 1) % 16;
        msize[k]--;
        if (msize[k] > 0 && mav[k][mhead[k]] < ecnt) mav[k][mhead[k]] = ecnt;
      end
      if (flush) msize[k] = 0;
      if (af[k]) begin
        idx = (mhead[k] + msize[k]) % 16;
        mdat[k][idx] = (inv ? ~a : a) & mask_of(k);
        mav[k][idx]  = ecnt + dep_of(k) - 1;
        msize[k]++;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("y_valid", k, obs_v(k), 64'(exp_valid(k)));
      chk("count", k, obs_c(k), 64'(msize[k]));
      if (exp_valid(k)) chk("y", k, obs_y(k), mdat[k][mhead[k]]);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    a_valid = 1'b0;
    flush   = 1'b0;
    y_ready = rdy;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic beat(input logic [63:0] data, input bit iv);
    a       = data;
    inv     = iv;
    a_valid = 1'b1;
    cycle();
  endtask

  initial begin
    rn = 1'b0; a = '0; a_valid = 1'b0; inv = 1'b0; flush = 1'b0; y_ready = 1'b0;
    model_reset();
    #2;
    chk_reset_outputs();
    rn = 1'b1;

    // Single inverted beat, Y_READY high throughout.
    y_ready = 1'b1;
    beat(64'h3C, 1'b1);
    idle(20, 1'b1);

    // Streaming with alternating polarity.
    y_ready = 1'b1;
    for (int i = 0; i < 16; i++) beat(64'(i), i[0]);
    idle(20, 1'b1);

    // Back-pressure: fill, stall, then simultaneous take and accept.
    y_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(64'h50 + 64'(i), 1'b0);
    y_ready = 1'b1;
    beat(64'hA5, 1'b1);
    idle(20, 1'b1);

    // FLUSH with A_VALID high, then normal accept.
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) beat(64'h70 + 64'(i), 1'b1);
    flush = 1'b1;
    beat(64'hEE, 1'b0);
    flush = 1'b0;
    beat(64'h81, 1'b0);
    idle(20, 1'b1);

    // Asynchronous reset between edges in mid-stream.
    y_ready = 1'b1;
    for (int i = 0; i < 5; i++) beat({$urandom, $urandom}, 1'(i));
    #2;
    rn = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs();
    @(negedge clk);
    #1;
    rn = 1'b1;
    for (int i = 0; i < 4; i++) beat(64'h1111_0000_0000_0000 + 64'(i * 3 + 1), 1'(i));
    idle(20, 1'b1);

    // All-ones pattern: fill every configuration to DEPTH, then drain.
    y_ready = 1'b0;
    for (int i = 0; i < 17; i++) beat({64{1'b1}}, ~i[0]);
    idle(20, 1'b1);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      a       = {$urandom, $urandom};
      inv     = 1'($urandom_range(0, 1));
      a_valid = ($urandom_range(0, 9) < 7);
      y_ready = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 99) < 3);
      cycle();
    end
    idle(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_12t_inv_pipe.md
Name: gf180mcu_osu_sc_12T_inv_pipe

Overview:
- Parametrised, elastic successor to the single-bit library inverter.
- Carries a WIDTH-bit bus through DEPTH registered stages with a valid/ready handshake.
- Each beat is either inverted or passed straight through, selected per beat at capture time.
- Used as a retiming and polarity-correction element between digital blocks built from the 12T cell set. Reports its own occupancy.

Parameters:
- WIDTH, 8: data bus width in bits; legal range 1..64.
- DEPTH, 4: number of register stages; legal range 1..16.
- CW, $clog2(DEPTH+1): width of the occupancy count. Derived; must not be overridden.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- A  input  WIDTH  input data beat.
- A_VALID  input  1  upstream beat present.
- A_READY  output  1  pipe accepts a beat this cycle.
- INV  input  1  1 = store ~A, 0 = store A; sampled only on accept.
- FLUSH  input  1  synchronous discard of all held beats.
- Y  output  WIDTH  output data (stage DEPTH-1).
- Y_VALID  output  1  output beat present.
- Y_READY  input  1  downstream accepts.
- COUNT  output  CW  number of occupied stages, 0..DEPTH.

Behaviour:
- Reset (RN low, asynchronous):
  - All stage valid bits and data clear to 0.
  - Outputs while reset is asserted: Y=0, Y_VALID=0, COUNT=0, A_READY=0.
  - Reset deasserts synchronously to CLK (external synchroniser). First edge after RN high is a normal cycle.
  - RN asserted mid-transfer discards all beats; no partial beat survives.
- Stage i holds v[i] and d[i]. Stage 0 is the input side; stage DEPTH-1 drives Y and Y_VALID.
- Ready chain (combinational):
  - r[DEPTH-1] = ~v[DEPTH-1] | Y_READY.
  - r[i] = ~v[i] | r[i+1].
  - A_READY = r[0] & ~FLUSH & RN.
- Transfers:
  - Accept: A_VALID & A_READY at the rising edge. d[0] <= INV ? ~A : A; v[0] <= 1.
  - Advance: when r[i+1] and v[i] are both set, stage i moves to i+1 on the edge.
  - A stage that is not refilled clears its valid when its contents move on.
  - Full throughput: one beat per cycle sustained when Y_READY is held high.
- Latency: a beat accepted at edge n appears on Y with Y_VALID=1 after edge n+DEPTH-1 (visible in the cycle following that edge), given no back-pressure. DEPTH=1 gives one-cycle latency.
- Output stability: while Y_VALID=1 and Y_READY=0, Y must not change. Inverting stages must never alter data already stored.
- INV is per beat. Toggling INV affects only beats accepted afterwards; beats already in flight keep their polarity.
- COUNT is the registered popcount of v[]:
  - +1 on accept only; -1 on output take only; unchanged when both or neither occur.
  - Saturation is impossible by construction; COUNT never exceeds DEPTH.
- Full: COUNT=DEPTH and Y_READY=0 gives A_READY=0. With Y_READY=1 the pipe still accepts (simultaneous take and accept).
- Empty: COUNT=0 gives Y_VALID=0. Y holds its last value (0 after reset) and is don't-care for checking.
- FLUSH (synchronous, highest priority):
  - On the edge where FLUSH=1, all v clear and COUNT becomes 0.
  - No accept occurs that cycle (A_READY forced 0).
  - An output take coinciding with FLUSH is honoured: Y_VALID & Y_READY completes, then the beat is gone.
  - Data registers are not cleared by FLUSH.
- Y_VALID never depends combinationally on Y_READY. A_READY depends combinationally on Y_READY through the ready chain; this is permitted.

Test Plan:
- Reset, then A=8'h3C, INV=1, A_VALID=1 for one cycle, Y_READY=1 -> Y=8'hC3 with Y_VALID=1 exactly 4 cycles after accept; COUNT 1 until the output is taken, then 0.
- Stream 8'h00,8'h01,...,8'h0F with INV alternating 0/1 per beat, Y_READY=1 -> outputs 00,FE,02,FC,...,F0 in order at one per cycle; A_READY stays 1 throughout.
- Y_READY=0, push 6 beats -> exactly 4 accepted, A_READY=0 while COUNT=4, Y frozen at the first beat; then Y_READY=1 with A_VALID=1 -> accept and take in the same cycle, COUNT stays 4.
- Fill 3 beats, pulse FLUSH with A_VALID=1 and Y_READY=0 -> COUNT=0, Y_VALID=0 next cycle, no beat accepted that cycle; next cycle accept resumes normally.
- Assert RN low asynchronously mid-stream (between clock edges) -> Y_VALID, Y, COUNT and A_READY go to 0 immediately; after release, the first beat accepted is the first beat out.
- Parameter sweep WIDTH=1/DEPTH=1 and WIDTH=64/DEPTH=16 -> latency equals DEPTH, COUNT reaches DEPTH exactly, inversion is correct on all bits (all-ones pattern becomes all-zeros).
